// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver and its
// sequential binary-to-BCD converter.
package ssd_pkg;

  localparam int BIN_W      = 13;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int ITER_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_t;

  // Segment patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit enables, active-low, bit0 = ones digit
  localparam logic [3:0] ANODE_ONES      = 4'b1110;
  localparam logic [3:0] ANODE_TENS      = 4'b1101;
  localparam logic [3:0] ANODE_HUNDREDS  = 4'b1011;
  localparam logic [3:0] ANODE_THOUSANDS = 4'b0111;
  localparam logic [3:0] ANODE_OFF       = 4'b1111;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] anode_code(input logic [1:0] sel);
    logic [3:0] code;
    case (sel)
      2'd0:    code = ANODE_ONES;
      2'd1:    code = ANODE_TENS;
      2'd2:    code = ANODE_HUNDREDS;
      default: code = ANODE_THOUSANDS;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. Watches num while idle, and whenever it
// differs from the last converted value runs a 13-iteration shift/add-3 pass,
// publishing the result on bcd only once the whole conversion is done.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] num,
  input  logic             start,
  output logic             busy,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t       state;
  conv_state_t       next_state;
  logic [BIN_W-1:0]  cur_bin;
  logic [BIN_W-1:0]  bin_sr;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  scratch_adj;
  logic [ITER_W-1:0] iter_cnt;
  logic              capture_en;
  logic              load_en;
  logic              shift_en;
  logic              commit_en;

  // State register; reset abandons any conversion in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state: leave IDLE only on a new value, count 13 shifts, then commit
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && (num != cur_bin)) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (iter_cnt == 4'd1) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state datapath strobes; busy covers LOAD through COMMIT
  always_comb begin
    capture_en = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    commit_en  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE:    capture_en = start && (num != cur_bin);
      LOAD:    begin load_en   = 1'b1; busy = 1'b1; end
      SHIFT:   begin shift_en  = 1'b1; busy = 1'b1; end
      COMMIT:  begin commit_en = 1'b1; busy = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  // Add-3 correction for every BCD nibble that would overflow on the next shift
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture, clear, shift and publish the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_bin  <= '0;
      bin_sr   <= '0;
      scratch  <= '0;
      iter_cnt <= '0;
      bcd      <= '0;
    end else begin
      if (capture_en) begin
        cur_bin <= num;
        bin_sr  <= num;
      end
      if (load_en) begin
        scratch  <= '0;
        iter_cnt <= ITER_W'(BIN_W);
      end
      if (shift_en) begin
        {scratch, bin_sr} <= {scratch_adj[BCD_W-2:0], bin_sr, 1'b0};
        iter_cnt          <= iter_cnt - 4'd1;
      end
      if (commit_en) bcd <= scratch;
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode display driver: converts num to BCD in the
// background and scans the committed digits across the anodes, with optional
// blanking of leading zeros on the upper three digits.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_BITS = 17,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        busy
);

  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]              digit_sel;
  logic [3:0]              digit_val;
  logic                    digit_blank;

  // The converter free-runs; it only ever acts when num changes
  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .num   (num),
    .start (1'b1),
    .busy  (busy),
    .bcd   (bcd)
  );

  assign digit_sel = scan_cnt[REFRESH_BITS-1 -: 2];

  // Pick the digit being scanned and decide whether it is a leading zero
  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    case (digit_sel)
      2'd0: digit_val = bcd[3:0];
      2'd1: begin
        digit_val   = bcd[7:4];
        digit_blank = BLANK_LZ && (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        digit_val   = bcd[11:8];
        digit_blank = BLANK_LZ && (bcd[15:8] == 8'd0);
      end
      default: begin
        digit_val   = bcd[15:12];
        digit_blank = BLANK_LZ && (bcd[15:12] == 4'd0);
      end
    endcase
  end

  // Scan counter plus registered anode/segment drive, updated on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      anode    <= ANODE_OFF;
      seg      <= SEG_BLANK;
    end else begin
      scan_cnt <= scan_cnt + REFRESH_BITS'(1);
      anode    <= anode_code(digit_sel);
      seg      <= digit_blank ? SEG_BLANK : seg_encode(digit_val);
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: two instances (leading-zero
// blanking on and off) with a short scan counter, checked against a decimal
// arithmetic model of the displayed value.
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] num = 13'd1234;
  logic [3:0]  anode, anode_nb;
  logic [6:0]  seg, seg_nb;
  logic [15:0] bcd, bcd_nb;
  logic        busy, busy_nb;

  int checks = 0;
  int errors = 0;
  int model_val = 0;
  int edge_cnt;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  ssd_scan_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .num(num), .anode(anode), .seg(seg), .bcd(bcd), .busy(busy)
  );

  ssd_scan_driver #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .num(num), .anode(anode_nb), .seg(seg_nb), .bcd(bcd_nb), .busy(busy_nb)
  );

  always #5 clk = ~clk;

  // Number of clock edges seen since reset was last released
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] exp_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int pos, input bit blz);
    int p10 = 1;
    for (int i = 0; i < pos; i++) p10 = p10 * 10;
    if (blz && pos > 0 && v < p10) return 7'b1111111;
    return seg_tab[(v / p10) % 10];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy !== 1'b0 && b < 64) begin
      tick(1);
      b++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_idle busy=%b expected 0 within 64 cycles", busy);
    end
  endtask

  // Apply a value at a negedge and check bcd holds, then updates on the 16th edge
  task automatic test_convert(input int v);
    logic [15:0] old_bcd = exp_bcd(model_val);
    wait_idle();
    @(negedge clk);
    num = 13'(v);
    if (v == model_val) begin
      tick(16);
      checks++;
      if (bcd !== old_bcd) begin
        errors++;
        $display("[TB] FAIL same_value bcd=%h expected %h", bcd, old_bcd);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL same_value busy=%b expected 0", busy);
      end
    end else begin
      for (int c = 0; c < 15; c++) begin
        tick(1);
        checks++;
        if (bcd !== old_bcd || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL converting v=%0d edge=%0d bcd=%h busy=%b expected %h busy 1",
                   v, c, bcd, busy, old_bcd);
        end
      end
      tick(1);
      checks++;
      if (bcd !== exp_bcd(v) || bcd_nb !== exp_bcd(v)) begin
        errors++;
        $display("[TB] FAIL commit v=%0d bcd=%h bcd_nb=%h expected %h", v, bcd, bcd_nb, exp_bcd(v));
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL commit_busy v=%0d busy=%b expected 0", v, busy);
      end
      model_val = v;
    end
  endtask

  // Compare both displays to the model over a run of scan cycles
  task automatic check_display(input int v, input int cycles);
    int pos;
    logic [3:0] ea;
    tick(1);
    for (int c = 0; c < cycles; c++) begin
      tick(1);
      pos = ((edge_cnt - 1) >> 2) & 3;
      ea  = ~(4'b0001 << pos);
      checks++;
      if (anode !== ea || anode_nb !== ea) begin
        errors++;
        $display("[TB] FAIL anode v=%0d got %b/%b expected %b", v, anode, anode_nb, ea);
      end
      checks++;
      if ($countones(~anode) != 1) begin
        errors++;
        $display("[TB] FAIL onehot anode=%b expected exactly one low", anode);
      end
      checks++;
      if (seg !== exp_seg(v, pos, 1'b1)) begin
        errors++;
        $display("[TB] FAIL seg v=%0d digit=%0d got %b expected %b", v, pos, seg, exp_seg(v, pos, 1'b1));
      end
      checks++;
      if (seg_nb !== exp_seg(v, pos, 1'b0)) begin
        errors++;
        $display("[TB] FAIL seg_nb v=%0d digit=%0d got %b expected %b", v, pos, seg_nb, exp_seg(v, pos, 1'b0));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (anode !== 4'b1111 || seg !== 7'b1111111 || bcd !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s anode=%b seg=%b bcd=%h busy=%b expected 1111 1111111 0000 0",
               tag, anode, seg, bcd, busy);
    end
    checks++;
    if (anode_nb !== 4'b1111 || seg_nb !== 7'b1111111 || bcd_nb !== 16'h0000 || busy_nb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_nb anode=%b seg=%b bcd=%h busy=%b expected 1111 1111111 0000 0",
               tag, anode_nb, seg_nb, bcd_nb, busy_nb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    num = 13'd1234;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      check_reset_outputs("reset_hold");
    end
    model_val = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      checks++;
      if (bcd !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_release edge=%0d bcd=%h expected 0000", c, bcd);
      end
    end
    tick(1);
    checks++;
    if (bcd !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL reset_release_commit bcd=%h expected 1234", bcd);
    end
    model_val = 1234;
  endtask

  task automatic test_max();
    test_convert(8191);
    check_display(8191, 16);
  endtask

  task automatic test_blanking();
    test_convert(7);
    check_display(7, 16);
    test_convert(105);
    check_display(105, 16);
  endtask

  // 42 is overtaken by 999 while busy; 999 starts right after 42 commits
  task automatic test_back_to_back();
    wait_idle();
    @(negedge clk);
    num = 13'd42;
    tick(3);
    @(negedge clk);
    num = 13'd999;
    tick(12);
    checks++;
    if (bcd !== exp_bcd(model_val)) begin
      errors++;
      $display("[TB] FAIL b2b_hold bcd=%h expected %h", bcd, exp_bcd(model_val));
    end
    tick(1);
    checks++;
    if (bcd !== 16'h0042 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first bcd=%h busy=%b expected 0042 busy 0", bcd, busy);
    end
    tick(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_gap busy=%b expected 1 after one idle cycle", busy);
    end
    tick(14);
    checks++;
    if (bcd !== 16'h0042) begin
      errors++;
      $display("[TB] FAIL b2b_hold2 bcd=%h expected 0042", bcd);
    end
    tick(1);
    checks++;
    if (bcd !== 16'h0999 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second bcd=%h busy=%b expected 0999 busy 0", bcd, busy);
    end
    model_val = 999;
    check_display(999, 16);
  endtask

  task automatic test_reset_mid();
    wait_idle();
    @(negedge clk);
    num = 13'd500;
    tick(7);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    tick(2);
    check_reset_outputs("reset_mid_hold");
    model_val = 0;
    @(negedge clk);
    rst = 1'b1;
    tick(15);
    checks++;
    if (bcd !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold bcd=%h expected 0000", bcd);
    end
    tick(1);
    checks++;
    if (bcd !== 16'h0500) begin
      errors++;
      $display("[TB] FAIL reset_mid_commit bcd=%h expected 0500", bcd);
    end
    model_val = 500;
  endtask

  task automatic test_zero_after_reset();
    int seen_busy = 0;
    @(negedge clk);
    rst = 1'b0;
    num = 13'd0;
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    model_val = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (busy !== 1'b0) seen_busy++;
    end
    checks++;
    if (seen_busy != 0 || bcd !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL zero_idle busy_cycles=%0d bcd=%h expected 0 and 0000", seen_busy, bcd);
    end
    check_display(0, 16);
  endtask

  task automatic test_scan_wrap();
    check_display(model_val, 64);
  endtask

  task automatic test_random();
    int v;
    for (int k = 0; k < 8; k++) begin
      v = int'($urandom_range(0, 8191));
      test_convert(v);
      check_display(v, 16);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_blanking();
    test_back_to_back();
    test_reset_mid();
    test_zero_after_reset();
    test_scan_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
